// File: rtl/hh_spike_detect.sv
// Spike detector for the Hodgkin-Huxley membrane stage: threshold crossing with
// refractory/hysteresis gating, spike count, inter-spike interval and peak voltage.
module hh_spike_detect #(
  parameter logic [13:0] V_THRESH    = 14'h0000,
  parameter logic [13:0] V_RESET     = 14'h3920,
  parameter int unsigned REFRACT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [13:0] v_in,
  output logic        spike,
  output logic [7:0]  spike_count,
  output logic [15:0] isi,
  output logic        isi_valid,
  output logic [13:0] v_peak,
  output logic        peak_done,
  output logic [1:0]  det_state
);

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    ACTIVE   = 2'd1,
    REFRACT  = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  localparam logic [7:0] REFRACT_LOAD = 8'(REFRACT_CYC);

  state_t      state;
  logic [7:0]  refr_cnt;
  logic [15:0] timer;
  logic        prev_seen;

  logic        above;
  logic        below_reset;
  logic        higher_peak;
  logic        detect;
  logic [15:0] timer_inc;

  always_comb begin
    above       = $signed(v_in) >= $signed(V_THRESH);
    below_reset = $signed(v_in) <  $signed(V_RESET);
    higher_peak = $signed(v_in) >  $signed(v_peak);
    detect      = (state == ARMED) && above;
    // saturating increment doubles as min(timer+1, FFFF) for the ISI capture
    timer_inc   = (timer == 16'hFFFF) ? timer : timer + 16'd1;
  end

  assign det_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ARMED;
      refr_cnt    <= '0;
      timer       <= '0;
      prev_seen   <= 1'b0;
      spike       <= 1'b0;
      spike_count <= '0;
      isi         <= '0;
      isi_valid   <= 1'b0;
      v_peak      <= '0;
      peak_done   <= 1'b0;
    end else begin
      spike     <= 1'b0;
      peak_done <= 1'b0;
      if (en) begin
        if (detect) begin
          timer     <= '0;
          prev_seen <= 1'b1;
          if (prev_seen) begin
            isi       <= timer_inc;
            isi_valid <= 1'b1;
          end
        end else begin
          timer <= timer_inc;
        end

        case (state)
          ARMED: begin
            if (above) begin
              state       <= ACTIVE;
              spike       <= 1'b1;
              spike_count <= spike_count + 8'd1;
              v_peak      <= v_in;
            end
          end
          ACTIVE: begin
            if (!above) begin
              state     <= REFRACT;
              peak_done <= 1'b1;
              refr_cnt  <= REFRACT_LOAD;
            end else if (higher_peak) begin
              v_peak <= v_in;
            end
          end
          REFRACT: begin
            if (refr_cnt == 8'd1) begin
              state <= below_reset ? ARMED : WAIT_LOW;
            end else begin
              refr_cnt <= refr_cnt - 8'd1;
            end
          end
          WAIT_LOW: begin
            if (below_reset) state <= ARMED;
          end
          default: state <= ARMED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hh_spike_detect.sv
// Self-checking bench for hh_spike_detect: constant vector table, directed
// corner sequences and randomized stimulus against a behavioural model.
module tb_hh_spike_detect;

  localparam logic [13:0] TH  = 14'h0000;
  localparam logic [13:0] VR  = 14'h3920;
  localparam int          REF = 16;
  localparam logic [13:0] NEG65 = 14'h37E0;
  localparam logic [13:0] POS10 = 14'h0140;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [13:0] v_in;
  logic        spike;
  logic [7:0]  spike_count;
  logic [15:0] isi;
  logic        isi_valid;
  logic [13:0] v_peak;
  logic        peak_done;
  logic [1:0]  det_state;

  hh_spike_detect #(.V_THRESH(TH), .V_RESET(VR), .REFRACT_CYC(REF)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .v_in(v_in),
    .spike(spike), .spike_count(spike_count), .isi(isi), .isi_valid(isi_valid),
    .v_peak(v_peak), .peak_done(peak_done), .det_state(det_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: spike in progress, refractory cycles left, waiting for a low sample.
  bit      m_in_spike, m_need_low, m_prev;
  int      m_left, m_timer, m_count;
  bit      m_spike, m_pdone, m_isv;
  int      m_isi, m_peak;

  function automatic int sv(input logic [13:0] v);
    return int'($signed(v));
  endfunction

  function automatic int m_state();
    if (m_in_spike) return 1;
    if (m_left > 0) return 2;
    if (m_need_low) return 3;
    return 0;
  endfunction

  task automatic model_edge(input logic r, input logic e, input logic [13:0] v);
    bit fired;
    fired = 0;
    m_spike = 0;
    m_pdone = 0;
    if (!r) begin
      m_in_spike = 0; m_need_low = 0; m_prev = 0; m_left = 0; m_timer = 0;
      m_count = 0; m_isv = 0; m_isi = 0; m_peak = 0;
    end else if (e) begin
      if (m_in_spike) begin
        if (sv(v) < sv(TH)) begin
          m_in_spike = 0; m_left = REF; m_pdone = 1;
        end else if (sv(v) > m_peak) m_peak = sv(v);
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_need_low = !(sv(v) < sv(VR));
      end else if (m_need_low) begin
        if (sv(v) < sv(VR)) m_need_low = 0;
      end else if (sv(v) >= sv(TH)) begin
        fired = 1; m_in_spike = 1; m_spike = 1;
        m_count = (m_count + 1) % 256; m_peak = sv(v);
      end
      if (fired) begin
        if (m_prev) begin
          m_isi = (m_timer + 1 > 65535) ? 65535 : m_timer + 1;
          m_isv = 1;
        end
        m_prev = 1;
        m_timer = 0;
      end else if (m_timer < 65535) m_timer++;
    end
  endtask

  task automatic check_model();
    cmp("spike", int'(spike), int'(m_spike));
    cmp("spike_count", int'(spike_count), m_count);
    cmp("isi", int'(isi), m_isi);
    cmp("isi_valid", int'(isi_valid), int'(m_isv));
    cmp("v_peak", sv(v_peak), m_peak);
    cmp("peak_done", int'(peak_done), int'(m_pdone));
    cmp("det_state", int'(det_state), m_state());
  endtask

  task automatic step(input logic r, input logic e, input logic [13:0] v);
    rst_n = r; en = e; v_in = v;
    @(posedge clk);
    #1;
    model_edge(r, e, v);
    check_model();
  endtask

  typedef struct {
    logic        r, e;
    logic [13:0] v;
    logic        sp;
    logic [7:0]  cnt;
    logic        pd;
    logic [13:0] peak;
    logic [1:0]  st;
    logic [15:0] isi;
    logic        isv;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic e, input logic [13:0] v,
                              input logic sp, input logic [7:0] cnt, input logic pd,
                              input logic [13:0] peak, input logic [1:0] st,
                              input logic [15:0] is, input logic isv);
    vec_t t;
    t.r = r; t.e = e; t.v = v; t.sp = sp; t.cnt = cnt; t.pd = pd;
    t.peak = peak; t.st = st; t.isi = is; t.isv = isv;
    return t;
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b1; v_in = 14'h0280;

    // Reset, release into spike, mid-spike reset, then the single-spike waveform.
    vecs.push_back(mk(0,1,14'h0280, 0,0,0,14'h0000,0, 0,0));
    vecs.push_back(mk(0,1,14'h0280, 0,0,0,14'h0000,0, 0,0));
    vecs.push_back(mk(1,1,14'h0280, 1,1,0,14'h0280,1, 0,0));
    vecs.push_back(mk(0,1,14'h0280, 0,0,0,14'h0000,0, 0,0));
    vecs.push_back(mk(1,1,NEG65,    0,0,0,14'h0000,0, 0,0));
    vecs.push_back(mk(1,1,14'h0140, 1,1,0,14'h0140,1, 0,0));
    vecs.push_back(mk(1,1,14'h0320, 0,1,0,14'h0320,1, 0,0));
    vecs.push_back(mk(1,1,14'h0100, 0,1,0,14'h0320,1, 0,0));
    vecs.push_back(mk(1,1,14'h3720, 0,1,1,14'h0320,2, 0,0));
    vecs.push_back(mk(1,0,14'h0280, 0,1,0,14'h0320,2, 0,0));
    for (int i = 0; i < REF - 1; i++)
      vecs.push_back(mk(1,1,14'h3720, 0,1,0,14'h0320,2, 0,0));
    vecs.push_back(mk(1,1,14'h3720, 0,1,0,14'h0320,0, 0,0));
    vecs.push_back(mk(1,1,TH,       1,2,0,14'h0000,1, 16'd20,1));
    vecs.push_back(mk(1,1,VR,       0,2,1,14'h0000,2, 16'd20,1));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].e, vecs[i].v);
      cmp($sformatf("vec%0d.spike", i), int'(spike), int'(vecs[i].sp));
      cmp($sformatf("vec%0d.count", i), int'(spike_count), int'(vecs[i].cnt));
      cmp($sformatf("vec%0d.pdone", i), int'(peak_done), int'(vecs[i].pd));
      cmp($sformatf("vec%0d.peak", i), int'(v_peak), int'(vecs[i].peak));
      cmp($sformatf("vec%0d.state", i), int'(det_state), int'(vecs[i].st));
      cmp($sformatf("vec%0d.isi", i), int'(isi), int'(vecs[i].isi));
      cmp($sformatf("vec%0d.isv", i), int'(isi_valid), int'(vecs[i].isv));
    end

    // ISI of 100 enabled edges, then a saturating gap.
    step(0,1,NEG65);
    step(1,1,NEG65);
    step(1,1,POS10);
    cmp("isi_first_spike", int'(spike), 1);
    cmp("isi_first_valid", int'(isi_valid), 0);
    repeat (99) step(1,1,NEG65);
    step(1,1,POS10);
    cmp("isi_100_spike", int'(spike), 1);
    cmp("isi_100", int'(isi), 100);
    cmp("isi_100_valid", int'(isi_valid), 1);
    repeat (65599) step(1,1,NEG65);
    step(1,1,POS10);
    cmp("isi_saturated", int'(isi), 16'hFFFF);

    // Crossing during refractory is ignored; after re-arm it counts.
    begin
      int c0;
      step(1,1,NEG65);
      c0 = int'(spike_count);
      repeat (9) step(1,1,NEG65);
      step(1,1,POS10);
      cmp("refr_ignored_spike", int'(spike), 0);
      cmp("refr_ignored_count", int'(spike_count), c0);
      cmp("refr_ignored_state", int'(det_state), 2);
      repeat (20) step(1,1,NEG65);
      step(1,1,POS10);
      cmp("refr_rearm_spike", int'(spike), 1);
      cmp("refr_rearm_count", int'(spike_count), (c0 + 1) % 256);
    end

    // Hysteresis: high at refractory end waits for a sample strictly below V_RESET.
    step(1,1,14'h3B00);
    repeat (REF) step(1,1,14'h3B00);
    cmp("hyst_wait_low", int'(det_state), 3);
    step(1,1,POS10);
    cmp("hyst_no_spike", int'(spike), 0);
    step(1,1,VR);
    cmp("hyst_eq_reset_holds", int'(det_state), 3);
    step(1,1,14'h3880);
    cmp("hyst_rearmed", int'(det_state), 0);
    step(1,1,POS10);
    cmp("hyst_spike", int'(spike), 1);

    // Stall: en=0 mid-refractory extends it by the stalled cycles.
    step(1,1,NEG65);
    repeat (5) step(1,1,NEG65);
    repeat (5) step(1,0,POS10);
    repeat (10) step(1,1,NEG65);
    cmp("stall_still_refract", int'(det_state), 2);
    step(1,1,NEG65);
    cmp("stall_rearmed", int'(det_state), 0);

    // 256 spikes wrap the counter back to 0.
    step(0,1,NEG65);
    step(1,1,NEG65);
    for (int k = 1; k <= 256; k++) begin
      step(1,1,POS10);
      cmp("wrap_count", int'(spike_count), k % 256);
      repeat (REF + 1) step(1,1,NEG65);
    end
    cmp("wrap_zero", int'(spike_count), 0);

    // Randomized traffic around the thresholds.
    for (int n = 0; n < 4000; n++) begin
      logic        r, e;
      logic [13:0] v;
      r = ($urandom_range(0, 299) != 0);
      e = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 6))
        0: v = NEG65;
        1: v = POS10;
        2: v = TH;
        3: v = VR;
        4: v = 14'h3880;
        5: v = 14'h3B00;
        default: v = 14'($urandom);
      endcase
      step(r, e, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
